window_watchdog_core: RTL

//  Windowed watchdog engine fed by configuration_register outputs (FWLEN, SWLEN, RST_LMT, WDSRVC, INIT).

---
 rtl/wdt_pkg.sv | 16 +
 rtl/wdt_prescaler.sv | 19 +
 rtl/window_watchdog_core.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wdt_pkg.sv
// wdt_pkg: state encodings, fault codes and a saturating increment shared by the watchdog.
package wdt_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FIRST  = 2'b01,
        ST_SECOND = 2'b10,
        ST_RESET  = 2'b11
    } wdt_state_e;
    localparam logic [2:0] FC_NONE    = 3'b000;
    localparam logic [2:0] FC_EARLY   = 3'b001;
    localparam logic [2:0] FC_TIMEOUT = 3'b010;
    localparam logic [2:0] FC_LIMIT   = 3'b100;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/wdt_prescaler.sv
// wdt_prescaler: divides CLK down to a one-cycle window tick, restartable by a sync clear.
module wdt_prescaler #(
    parameter int PRESC_DIV = 1000,
    parameter int PRESC_W   = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    output logic o_tick
);
    logic [PRESC_W-1:0] r_cnt;
    assign o_tick = r_cnt == PRESC_W'(PRESC_DIV - 1);
    always_ff @(posedge CLK) begin
        if (RST || i_clr || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/window_watchdog_core.sv
// window_watchdog_core: closed/open window watchdog with fault counting and system reset pulse.
module window_watchdog_core
    import wdt_pkg::*;
#(
    parameter int PRESC_DIV = 1000,
    parameter int PRESC_W   = 10,
    parameter int RST_PULSE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] FWLEN,
    input  logic [7:0] SWLEN,
    input  logic [7:0] RST_LMT,
    input  logic       WDSRVC,
    input  logic       INIT,
    output logic [1:0] STATE,
    output logic [7:0] FLT_CNT,
    output logic [2:0] FLT_CODE,
    output logic       WD_FAULT,
    output logic       SYS_RST
);
    localparam int RC_W = $clog2(RST_PULSE + 1);

    wdt_state_e r_state, w_next, w_win_st;
    logic [7:0] r_wcnt, r_fw, r_sw, r_flt_cnt, w_len, w_cnt_inc;
    logic [2:0] r_flt_code, w_code;
    logic [RC_W-1:0] r_rcnt;
    logic r_srv_q, r_wd_fault, r_sys_rst;
    logic w_srv, w_tick, w_end, w_enter, w_fault, w_limit, w_rst_done, w_win_next, w_clr;

    assign w_srv      = WDSRVC & ~r_srv_q;
    assign w_len      = (r_state == ST_FIRST) ? r_fw : ((r_sw == 8'd0) ? 8'd1 : r_sw);
    assign w_end      = w_tick && (r_wcnt == w_len - 8'd1);
    assign w_win_st   = (FWLEN == 8'd0) ? ST_SECOND : ST_FIRST;
    assign w_cnt_inc  = sat_inc(r_flt_cnt);
    assign w_limit    = (RST_LMT != 8'd0) && (w_cnt_inc >= RST_LMT);
    assign w_rst_done = (r_state == ST_RESET) && (r_rcnt == RC_W'(RST_PULSE - 1));
    assign w_win_next = (w_next == ST_FIRST) || (w_next == ST_SECOND);
    // Counters are held cleared outside the windows and restart on every window entry.
    assign w_clr      = w_enter || !w_win_next;

    wdt_prescaler #(.PRESC_DIV(PRESC_DIV), .PRESC_W(PRESC_W)) u_presc (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_clr),
        .o_tick(w_tick)
    );

    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_fault = 1'b0;
        w_code  = FC_NONE;
        case (r_state)
            ST_IDLE: begin
                w_next  = INIT ? w_win_st : ST_IDLE;
                w_enter = INIT;
            end
            ST_FIRST: begin
                if (!INIT)
                    w_next = ST_IDLE;
                else if (w_srv) begin
                    w_fault = 1'b1;
                    w_code  = FC_EARLY;
                end else if (w_end) begin
                    w_next  = ST_SECOND;
                    w_enter = 1'b1;
                end
            end
            ST_SECOND: begin
                if (!INIT)
                    w_next = ST_IDLE;
                else if (w_srv) begin
                    w_next  = w_win_st;
                    w_enter = 1'b1;
                end else if (w_end) begin
                    w_fault = 1'b1;
                    w_code  = FC_TIMEOUT;
                end
            end
            default: begin
                w_next  = w_rst_done ? (INIT ? w_win_st : ST_IDLE) : ST_RESET;
                w_enter = w_rst_done && INIT;
            end
        endcase
        if (w_fault) begin
            w_next  = w_limit ? ST_RESET : w_win_st;
            w_enter = !w_limit;
            w_code  = w_limit ? FC_LIMIT : w_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= 8'd0;
            r_fw       <= 8'd0;
            r_sw       <= 8'd0;
            r_flt_cnt  <= 8'd0;
            r_flt_code <= FC_NONE;
            r_rcnt     <= '0;
            r_srv_q    <= 1'b0;
            r_wd_fault <= 1'b0;
            r_sys_rst  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_srv_q    <= WDSRVC;
            r_wd_fault <= w_fault;
            r_sys_rst  <= w_next == ST_RESET;
            r_rcnt     <= (r_state == ST_RESET) ? r_rcnt + 1'b1 : '0;
            r_wcnt     <= w_clr ? 8'd0 : (w_tick ? r_wcnt + 8'd1 : r_wcnt);
            if (w_enter) begin
                r_fw <= FWLEN;
                r_sw <= SWLEN;
            end
            if (w_fault) begin
                r_flt_cnt  <= w_cnt_inc;
                r_flt_code <= w_code;
            end else if (w_rst_done)
                r_flt_cnt <= 8'd0;
        end
    end

    assign STATE    = r_state;
    assign FLT_CNT  = r_flt_cnt;
    assign FLT_CODE = r_flt_code;
    assign WD_FAULT = r_wd_fault;
    assign SYS_RST  = r_sys_rst;
endmodule
